dmem_arbiter: RTL and testbench

//   Shares the single-port data memory (data_mem) between two requesters: port 0 (core load/store

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_lane_align.sv | 39 +++
 rtl/dmem_arbiter.sv | 101 ++++++++++
 tb/tb_dmem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } size_t;

  typedef logic port_id_t;
  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size_t'(size))
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane handling: store merge into the read word and load extract/extend.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] mem_rd,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  off,
  output logic [31:0] mem_wd,
  output logic [31:0] rdata
);

  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  always_comb begin
    ld_b   = mem_rd[{off, 3'b000} +: 8];
    ld_h   = off[1] ? mem_rd[31:16] : mem_rd[15:0];
    mem_wd = mem_rd;
    rdata  = mem_rd;
    case (size_t'(size))
      SZ_B: begin
        mem_wd[{off, 3'b000} +: 8] = wdata[7:0];
        rdata = {{24{~uns & ld_b[7]}}, ld_b};
      end
      SZ_H: begin
        if (off[1]) mem_wd[31:16] = wdata[15:0];
        else        mem_wd[15:0]  = wdata[15:0];
        rdata = {{16{~uns & ld_h[15]}}, ld_h};
      end
      default: begin
        mem_wd = wdata;
        rdata  = mem_rd;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing single-port data memory between the LSU (port 0) and a loader (port 1).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_BYTES = 256,
  parameter bit P0_FIRST  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic        p0_req_we,
  input  logic [1:0]  p0_req_size,
  input  logic        p0_req_unsigned,
  input  logic [31:0] p0_req_addr,
  input  logic [31:0] p0_req_wdata,
  output logic        p0_rsp_valid,
  output logic [31:0] p0_rsp_rdata,
  output logic        p0_rsp_err,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic        p1_req_we,
  input  logic [1:0]  p1_req_size,
  input  logic        p1_req_unsigned,
  input  logic [31:0] p1_req_addr,
  input  logic [31:0] p1_req_wdata,
  output logic        p1_rsp_valid,
  output logic [31:0] p1_rsp_rdata,
  output logic        p1_rsp_err,
  output logic [31:0] mem_a,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  port_id_t         ptr, win;
  logic             grant, err, sel_we, sel_uns;
  logic [1:0]       sel_size, hit;
  logic [31:0]      sel_addr, sel_wdata, ld_data, mem_a_q;
  logic [1:0]       rsp_vld, rsp_err;
  logic [1:0][31:0] rsp_rdata;

  // No grant while reset is high, so nothing is accepted or written in a reset cycle.
  always_comb begin
    grant = ~reset & (p0_req_valid | p1_req_valid);
    win   = (p0_req_valid & p1_req_valid) ? ptr : (p0_req_valid ? PORT0 : PORT1);
    if (win == PORT1) begin
      sel_we = p1_req_we; sel_size = p1_req_size; sel_uns = p1_req_unsigned;
      sel_addr = p1_req_addr; sel_wdata = p1_req_wdata;
    end else begin
      sel_we = p0_req_we; sel_size = p0_req_size; sel_uns = p0_req_unsigned;
      sel_addr = p0_req_addr; sel_wdata = p0_req_wdata;
    end
    err = (size_t'(sel_size) == SZ_X) | is_misaligned(sel_size, sel_addr[1:0])
        | (sel_addr >= 32'(MEM_BYTES));
    hit = {grant & (win == PORT1), grant & (win == PORT0)};
  end

  dmem_lane_align u_align (
    .mem_rd (mem_rd),
    .wdata  (sel_wdata),
    .size   (sel_size),
    .uns    (sel_uns),
    .off    (sel_addr[1:0]),
    .mem_wd (mem_wd),
    .rdata  (ld_data)
  );

  assign p0_req_ready = hit[0];
  assign p1_req_ready = hit[1];
  assign mem_we       = grant & sel_we & ~err;
  assign mem_a        = reset ? 32'h0 : (grant ? {sel_addr[31:2], 2'b00} : mem_a_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= P0_FIRST ? PORT0 : PORT1;
      mem_a_q   <= '0;
      rsp_vld   <= '0;
      rsp_err   <= '0;
      rsp_rdata <= '0;
    end else begin
      if (grant) begin
        ptr     <= ~win;
        mem_a_q <= {sel_addr[31:2], 2'b00};
      end
      rsp_vld <= hit;
      rsp_err <= hit & {2{err}};
      for (int i = 0; i < 2; i++)
        if (hit[i]) rsp_rdata[i] <= (sel_we | err) ? 32'h0 : ld_data;
    end
  end

  // Gated so a response registered just before reset never reaches the requester.
  assign p0_rsp_valid = rsp_vld[0] & ~reset;
  assign p1_rsp_valid = rsp_vld[1] & ~reset;
  assign p0_rsp_err   = rsp_err[0] & ~reset;
  assign p1_rsp_err   = rsp_err[1] & ~reset;
  assign p0_rsp_rdata = reset ? 32'h0 : rsp_rdata[0];
  assign p1_rsp_rdata = reset ? 32'h0 : rsp_rdata[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vectors, random traffic against a byte-array model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req_valid, p0_req_ready, p0_req_we, p0_req_unsigned;
  logic [1:0]  p0_req_size;
  logic [31:0] p0_req_addr, p0_req_wdata, p0_rsp_rdata;
  logic        p0_rsp_valid, p0_rsp_err;
  logic        p1_req_valid, p1_req_ready, p1_req_we, p1_req_unsigned;
  logic [1:0]  p1_req_size;
  logic [31:0] p1_req_addr, p1_req_wdata, p1_rsp_rdata;
  logic        p1_rsp_valid, p1_rsp_err;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;

  int errors = 0;
  int checks = 0;

  logic [31:0] dmem [0:63];
  logic [7:0]  ref_mem [0:255];

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(256), .P0_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_size(p0_req_size), .p0_req_unsigned(p0_req_unsigned), .p0_req_addr(p0_req_addr),
    .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
    .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_size(p1_req_size), .p1_req_unsigned(p1_req_unsigned), .p1_req_addr(p1_req_addr),
    .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
    .p1_rsp_err(p1_rsp_err),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Environment memory: combinational read, write on posedge.
  assign mem_rd = (mem_a < 32'd256) ? dmem[mem_a[7:2]] : 32'h0;
  always @(posedge clk) if (mem_we && mem_a < 32'd256) dmem[mem_a[7:2]] <= mem_wd;

  // Reference: byte-addressed little-endian memory with the access rules applied directly.
  function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic er);
    int n;
    n  = 1 << sz;
    er = (sz == 2'd3) || (addr % n != 0) || (addr >= 32'd256);
    rd = 32'h0;
    if (!er) begin
      if (we) for (int i = 0; i < n; i++) ref_mem[addr + i] = wdata[8*i +: 8];
      else begin
        for (int i = 0; i < n; i++) rd[8*i +: 8] = ref_mem[addr + i];
        if (!uns && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8*n));
      end
    end
  endfunction

  task automatic drive(input int port, input logic v, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      p0_req_valid = v; p0_req_we = we; p0_req_size = sz; p0_req_unsigned = uns;
      p0_req_addr = addr; p0_req_wdata = wdata;
    end else begin
      p1_req_valid = v; p1_req_we = we; p1_req_size = sz; p1_req_unsigned = uns;
      p1_req_addr = addr; p1_req_wdata = wdata;
    end
  endtask

  // Called and returns just after a posedge; reports handshake, write-enable seen at grant,
  // and the response sampled one cycle after the handshake.
  task automatic issue(input int port, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic hs, output logic we_seen, output logic rv,
                       output logic [31:0] rd, output logic er);
    hs = 1'b0; we_seen = 1'b0;
    drive(port, 1'b1, we, sz, uns, addr, wdata);
    for (int i = 0; i < 8 && !hs; i++) begin
      @(negedge clk);
      if ((port == 0) ? p0_req_ready : p1_req_ready) begin hs = 1'b1; we_seen = mem_we; end
      @(posedge clk); #1;
    end
    drive(port, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rv = (port == 0) ? p0_rsp_valid : p1_rsp_valid;
    rd = (port == 0) ? p0_rsp_rdata : p1_rsp_rdata;
    er = (port == 0) ? p0_rsp_err   : p1_rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err, mem_we} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b required 0000000",
        {p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err, mem_we});
    end
    checks++;
    if (p0_rsp_rdata !== 32'h0 || p1_rsp_rdata !== 32'h0 || mem_a !== 32'h0) begin
      errors++; $display("FAIL reset_data got %h %h %h required 0 0 0", p0_rsp_rdata, p1_rsp_rdata, mem_a);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_a !== 32'h0 || mem_we !== 1'b0 || p0_req_ready !== 1'b0 || p1_req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_idle got mem_a=%h we=%b rdy=%b%b required 0 0 00",
        mem_a, mem_we, p0_req_ready, p1_req_ready);
    end
    @(posedge clk); #1;
  endtask

  typedef struct packed {
    logic        port; logic we; logic [1:0] sz; logic uns;
    logic [31:0] addr; logic [31:0] wdata; logic [31:0] rd; logic er;
  } vec_t;

  task automatic test_directed();
    vec_t v [19];
    logic hs, wes, rv, er, mer; logic [31:0] rd, mrd;
    v[0]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    v[1]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    v[2]  = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h11,  32'h000000A5, 32'h0,        1'b0};
    v[3]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h11,  32'h0,        32'hFFFFFFA5, 1'b0};
    v[4]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h11,  32'h0,        32'h000000A5, 1'b0};
    v[5]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEADA5EF, 1'b0};
    v[6]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h22,  32'h00008001, 32'h0,        1'b0};
    v[7]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h22,  32'h0,        32'hFFFF8001, 1'b0};
    v[8]  = '{1'b0, 1'b0, 2'd1, 1'b1, 32'h22,  32'h0,        32'h00008001, 1'b0};
    v[9]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h20,  32'h0,        32'h80010000, 1'b0};
    v[10] = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h13,  32'h0,        32'h0,        1'b1};
    v[11] = '{1'b1, 1'b1, 2'd1, 1'b0, 32'h21,  32'h00001234, 32'h0,        1'b1};
    v[12] = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1};
    v[13] = '{1'b1, 1'b1, 2'd3, 1'b0, 32'h10,  32'hFFFFFFFF, 32'h0,        1'b1};
    v[14] = '{1'b0, 1'b0, 2'd3, 1'b0, 32'h10,  32'h0,        32'h0,        1'b1};
    v[15] = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEADA5EF, 1'b0};
    v[16] = '{1'b0, 1'b1, 2'd2, 1'b0, 32'hFC,  32'h12345678, 32'h0,        1'b0};
    v[17] = '{1'b1, 1'b0, 2'd0, 1'b1, 32'hFF,  32'h0,        32'h00000012, 1'b0};
    v[18] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0,        32'h0,        1'b1};
    for (int i = 0; i < 19; i++) begin
      model(v[i].we, v[i].sz, v[i].uns, v[i].addr, v[i].wdata, mrd, mer);
      issue(int'(v[i].port), v[i].we, v[i].sz, v[i].uns, v[i].addr, v[i].wdata, hs, wes, rv, rd, er);
      checks++;
      if (!hs || rv !== 1'b1) begin
        errors++; $display("FAIL dir%0d_handshake got hs=%b rsp_valid=%b required 1 1", i, hs, rv);
      end
      checks++;
      if (rd !== v[i].rd || er !== v[i].er) begin
        errors++; $display("FAIL dir%0d_rsp got rdata=%h err=%b required %h %b", i, rd, er, v[i].rd, v[i].er);
      end
      if (v[i].we) begin
        checks++;
        if (wes !== ~v[i].er) begin
          errors++; $display("FAIL dir%0d_mem_we got %b required %b", i, wes, ~v[i].er);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w, mrd; logic mer;
    w = $urandom;
    model(1'b1, 2'd2, 1'b0, 32'h40, w, mrd, mer);
    drive(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h40, w);
    @(negedge clk);
    checks++;
    if (p0_req_ready !== 1'b1 || mem_we !== 1'b1) begin
      errors++; $display("FAIL b2b_store_grant got rdy=%b we=%b required 1 1", p0_req_ready, mem_we);
    end
    @(posedge clk); #1 drive(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    checks++;
    if (p0_req_ready !== 1'b1 || p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL b2b_load_grant got rdy=%b rv=%b rd=%h required 1 1 0",
        p0_req_ready, p0_rsp_valid, p0_rsp_rdata);
    end
    @(posedge clk); #1 drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== w) begin
      errors++; $display("FAIL b2b_load_rsp got rv=%b rd=%h required 1 %h", p0_rsp_valid, p0_rsp_rdata, w);
    end
    checks++;
    if (mem_a !== 32'h40 || mem_we !== 1'b0 || p0_req_ready !== 1'b0) begin
      errors++; $display("FAIL idle_hold got mem_a=%h we=%b rdy=%b required 40 0 0", mem_a, mem_we, p0_req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic hs, wes, rv, er, mer, we, uns; logic [1:0] sz; logic [31:0] rd, mrd, addr, w;
    int port;
    for (int i = 0; i < 40; i++) begin
      port = int'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = $urandom_range(0, 32'h10F);
      if ($urandom_range(0, 4) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
      w    = $urandom;
      model(we, sz, uns, addr, w, mrd, mer);
      issue(port, we, sz, uns, addr, w, hs, wes, rv, rd, er);
      checks++;
      if (!hs || rv !== 1'b1 || rd !== mrd || er !== mer || (we && wes !== ~mer)) begin
        errors++;
        $display("FAIL rand%0d p%0d we=%b sz=%0d a=%h got hs=%b rv=%b rd=%h err=%b wr=%b required 1 1 %h %b %b",
          i, port, we, sz, addr, hs, rv, rd, er, wes, mrd, mer, we & ~mer);
      end
    end
  endtask

  task automatic test_contention();
    int n0 = 0, n1 = 0;
    logic [31:0] e0, e1; logic er;
    do_reset(2);
    model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e0, er);
    model(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, e1, er);
    drive(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    drive(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    for (int c = 0; c < 7; c++) begin
      if (c == 6) begin
        drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
      end
      @(negedge clk);
      if (p0_rsp_valid) begin
        n0++; checks++;
        if (p0_rsp_rdata !== e0) begin errors++; $display("FAIL rr_p0_data got %h required %h", p0_rsp_rdata, e0); end
      end
      if (p1_rsp_valid) begin
        n1++; checks++;
        if (p1_rsp_rdata !== e1) begin errors++; $display("FAIL rr_p1_data got %h required %h", p1_rsp_rdata, e1); end
      end
      if (c < 6) begin
        checks++;
        if ({p0_req_ready, p1_req_ready} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL rr_grant%0d got %b%b required %s", c, p0_req_ready, p1_req_ready,
            (c % 2 == 0) ? "10" : "01");
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (n0 != 3 || n1 != 3) begin
      errors++; $display("FAIL rr_rsp_count got p0=%0d p1=%0d required 3 3", n0, n1);
    end
  endtask

  task automatic test_reset_mid();
    logic hs, wes, rv, er, mer; logic [31:0] rd, mrd;
    model(1'b1, 2'd2, 1'b0, 32'h30, 32'h11223344, mrd, mer);
    drive(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h30, 32'h11223344);
    @(negedge clk);
    checks++;
    if (p0_req_ready !== 1'b1) begin errors++; $display("FAIL rmid_grant got %b required 1", p0_req_ready); end
    @(posedge clk); #1;
    reset = 1'b1;
    drive(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h34, 32'hCAFEF00D);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (p0_rsp_valid !== 1'b0 || mem_we !== 1'b0 || p0_req_ready !== 1'b0) begin
        errors++; $display("FAIL rmid_in_reset%0d got rv=%b we=%b rdy=%b required 0 0 0",
          c, p0_rsp_valid, mem_we, p0_req_ready);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (p0_rsp_valid !== 1'b0 || mem_a !== 32'h0) begin
      errors++; $display("FAIL rmid_after got rv=%b mem_a=%h required 0 0", p0_rsp_valid, mem_a);
    end
    @(posedge clk); #1;
    model(1'b0, 2'd2, 1'b0, 32'h34, 32'h0, mrd, mer);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h34, 32'h0, hs, wes, rv, rd, er);
    checks++;
    if (!hs || rv !== 1'b1 || rd !== mrd) begin
      errors++; $display("FAIL rmid_no_write got hs=%b rv=%b rd=%h required 1 1 %h", hs, rv, rd, mrd);
    end
    model(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, mrd, mer);
    issue(1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, hs, wes, rv, rd, er);
    checks++;
    if (!hs || rv !== 1'b1 || rd !== mrd) begin
      errors++; $display("FAIL rmid_store_kept got hs=%b rv=%b rd=%h required 1 1 %h", hs, rv, rd, mrd);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) dmem[i] = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h0;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_contention();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
